fb_scanout_reader: RTL and testbench

//  Read side of the camera frame buffer: scans one stored frame out of the buffer RAM in raster order.

---
 rtl/fb_scanout_reader_pkg.sv | 20 ++
 rtl/fb_out_fifo2.sv | 44 ++++
 rtl/fb_scanout_reader.sv | 134 +++++++++++++
 tb/tb_fb_scanout_reader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_scanout_reader_pkg.sv
// Shared constants for the frame-buffer read side: FSM encodings and default geometry
// common with the CSI-2 write side.
package fb_scanout_reader_pkg;

  localparam int FB_H_RES  = 640;
  localparam int FB_V_RES  = 480;
  localparam int FB_ADDR_W = 20;
  localparam int FB_DATA_W = 8;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
  localparam logic [1:0] ST_STREAM     = 2'd2;
  localparam logic [1:0] ST_DRAIN      = 2'd3;

  // Counter width that stays at least 1 bit for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fb_out_fifo2.sv
// Two-entry output FIFO carrying {sof, eol, eof, pixel}; head is visible while count != 0.
module fb_out_fifo2 #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic         wr_ptr;
  logic         rd_ptr;

  assign head = rd_ptr ? mem1 : mem0;

  // The producer's credit check guarantees no push when full and no pop when empty.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem0   <= '0;
      mem1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) mem1 <= push_data;
        else        mem0 <= push_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fb_scanout_reader.sv
// Raster scan-out of one stored frame as a valid/ready pixel stream with SOF/EOL/EOF.
// Optional build macro: FB_READ_MIRROR_EN (horizontal mirror of each line).
module fb_scanout_reader
  import fb_scanout_reader_pkg::*;
#(
  parameter int H_RES     = FB_H_RES,
  parameter int V_RES     = FB_V_RES,
  parameter int ADDR_W    = FB_ADDR_W,
  parameter int DATA_W    = FB_DATA_W,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              frame_ready,
  input  logic              buf_we,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int XW = cnt_w(H_RES);
  localparam int YW = cnt_w(V_RES);
  localparam int FW = DATA_W + 3;
  localparam longint unsigned LAST_ADDR =
    longint'(BASE_ADDR) + longint'(H_RES) * longint'(V_RES) - 64'd1;
  localparam bit ADDR_FITS = (ADDR_W >= 64) || (LAST_ADDR < (64'd1 << ADDR_W));

  logic [1:0]        state;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [XW-1:0]     col;
  logic [ADDR_W-1:0] line_base;
  logic              inflight;
  logic [2:0]        inflight_mk;
  logic [2:0]        issue_mk;
  logic [2:0]        occ;
  logic              issue;
  logic              pop;
  logic              x_last;
  logic              y_last;
  logic [1:0]        fifo_count;
  logic [FW-1:0]     head;

  assign x_last = (x == XW'(H_RES - 1));
  assign y_last = (y == YW'(V_RES - 1));

`ifdef FB_READ_MIRROR_EN
  assign col = XW'(H_RES - 1) - x;
`else
  assign col = x;
`endif

  // Outside STREAM the address rests on the current line base (BASE_ADDR when idle).
  assign rd_addr = (state == ST_STREAM) ? line_base + ADDR_W'(col) : line_base;

  // Credit counts a same-cycle pop so a steady stream sustains one pixel per cycle.
  assign occ      = {1'b0, fifo_count} + {2'b00, inflight};
  assign pop      = m_valid && m_ready;
  assign issue    = (state == ST_STREAM) && !buf_we && (occ < (3'd2 + {2'b00, pop}));
  assign issue_mk = {(x == '0) && (y == '0), x_last, x_last && y_last};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      x           <= '0;
      y           <= '0;
      line_base   <= ADDR_W'(BASE_ADDR);
      inflight    <= 1'b0;
      inflight_mk <= 3'b000;
      done        <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) inflight_mk <= issue_mk;
      case (state)
        ST_IDLE: begin
          x         <= '0;
          y         <= '0;
          line_base <= ADDR_W'(BASE_ADDR);
          if (start) state <= ST_WAIT_FRAME;
        end
        ST_WAIT_FRAME: if (frame_ready) state <= ST_STREAM;
        ST_STREAM: if (issue) begin
          if (x_last) begin
            x         <= '0;
            y         <= y + 1'b1;
            line_base <= line_base + ADDR_W'(H_RES);
            if (y_last) state <= ST_DRAIN;
          end else begin
            x <= x + 1'b1;
          end
        end
        ST_DRAIN: if (pop && head[DATA_W]) begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fb_out_fifo2 #(.W(FW)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (inflight),
    .push_data ({inflight_mk, rd_data}),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  // Stale head contents are masked so every stream output reads 0 when nothing is valid.
  assign m_valid   = (fifo_count != 2'd0);
  assign m_data    = m_valid ? head[DATA_W-1:0] : '0;
  assign m_eof     = m_valid && head[DATA_W];
  assign m_eol     = m_valid && head[DATA_W+1];
  assign m_sof     = m_valid && head[DATA_W+2];
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (resetn) assert (ADDR_FITS) else $error("fb_scanout_reader: last frame address exceeds ADDR_W");
  end

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Bench for fb_scanout_reader on a 4x2 frame at base 16; RAM model returns addr[7:0].
module tb_fb_scanout_reader;

  localparam int H = 4;
  localparam int V = 2;
  localparam int BASE = 16;
  localparam int AW = 20;
  localparam int DW = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
`ifdef FB_READ_MIRROR_EN
  localparam bit MIRROR = 1'b1;
`else
  localparam bit MIRROR = 1'b0;
`endif

  logic          clk;
  logic          resetn;
  logic          start;
  logic          frame_ready;
  logic          buf_we;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_sof;
  logic          m_eol;
  logic          m_eof;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  fb_scanout_reader #(
    .H_RES(H), .V_RES(V), .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .frame_ready(frame_ready),
    .buf_we(buf_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // buffer RAM: registered read, suppressed while the writer is writing
  always @(posedge clk) if (!buf_we) rd_data <= rd_addr[7:0];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pix_cnt = 0;
  int done_cnt = 0;
  int last_pop = 0;
  int rdy_mode = 0;
  int pat_i = 0;
  logic [3:0]  rdy_pat = 4'b1001;
  logic        mon_en = 1'b0;
  logic        gap_chk = 1'b0;
  logic        exp_done_n = 1'b0;
  logic        stall_prev = 1'b0;
  logic [11:0] stall_val = '0;
  logic [10:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: begin m_ready = rdy_pat[pat_i]; pat_i = (pat_i + 1) % 4; end
      2: m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b1;
    endcase
  end

  // scoreboard / monitor
  always @(negedge clk) begin
    logic [10:0] cur;
    logic [10:0] e;
    cur = {m_sof, m_eol, m_eof, m_data};
    if (mon_en) begin
      if (exp_done_n) begin
        check_val("done_pulse", {31'd0, done}, 32'd1);
        check_val("busy_after_eof", {31'd0, busy}, 32'd0);
        exp_done_n = 1'b0;
        done_cnt++;
      end else if (done) begin
        check_val("done_spurious", {31'd0, done}, 32'd0);
      end
      if (stall_prev) check_val("stall_hold", {20'd0, m_valid, cur}, {20'd0, stall_val});
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check_val("extra_pixel", {21'd0, cur}, 32'h7ff);
        end else begin
          e = exp_q.pop_front();
          check_val("pixel", {21'd0, cur}, {21'd0, e});
          if (gap_chk && !cur[10]) check_val("gap", cyc, last_pop + 1);
          last_pop = cyc;
          pix_cnt++;
          if (e[8]) exp_done_n = 1'b1;
        end
      end
      stall_prev = m_valid && !m_ready;
      stall_val  = {m_valid, cur};
    end
  end

  // driver tasks
  task automatic push_frame_exp();
    for (int yy = 0; yy < V; yy++) begin
      for (int xx = 0; xx < H; xx++) begin
        int a;
        logic s, l, f;
        a = BASE + yy * H + (MIRROR ? (H - 1 - xx) : xx);
        s = (xx == 0) && (yy == 0);
        l = (xx == H - 1);
        f = l && (yy == V - 1);
        exp_q.push_back({s, l, f, a[7:0]});
      end
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt >= target) break;
    end
    check_val("frame_done", {31'd0, done_cnt >= target}, 32'd1);
  endtask

  task automatic wait_pix(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (pix_cnt >= target) break;
    end
    check_val("pix_progress", {31'd0, pix_cnt >= target}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_valid"}, {31'd0, m_valid}, 32'd0);
    check_val({tag, "_data"}, {24'd0, m_data}, 32'd0);
    check_val({tag, "_marks"}, {29'd0, m_sof, m_eol, m_eof}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_done"}, {31'd0, done}, 32'd0);
    check_val({tag, "_addr"}, {12'd0, rd_addr}, BASE);
    check_val({tag, "_state"}, {30'd0, dbg_state}, {30'd0, S_IDLE});
  endtask

  initial begin
    logic [AW-1:0] held;
    resetn = 1'b0; start = 1'b0; frame_ready = 1'b0; buf_we = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    resetn = 1'b1;
    mon_en = 1'b1;

    // back-to-back frame with one-pixel-per-cycle check
    gap_chk = 1'b1;
    frame_ready = 1'b1;
    push_frame_exp();
    do_start();
    wait_done(1, 100);
    gap_chk = 1'b0;

    // writer holds the RAM for 3 cycles mid-line
    push_frame_exp();
    do_start();
    wait_pix(pix_cnt + 2, 50);
    #1 buf_we = 1'b1;
    @(negedge clk) held = rd_addr;
    repeat (2) begin
      @(negedge clk);
      check_val("addr_held", {12'd0, rd_addr}, {12'd0, held});
    end
    @(posedge clk); #1 buf_we = 1'b0;
    wait_done(2, 100);

    // backpressure pattern 1,0,0,1 plus a start while busy that must be ignored
    rdy_mode = 1;
    push_frame_exp();
    do_start();
    repeat (4) @(posedge clk);
    do_start();
    wait_done(3, 200);
    rdy_mode = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_val("no_extra_frame", {31'd0, busy}, 32'd0);
    check_val("q_empty_3", exp_q.size(), 0);

    // start before the writer has a frame
    frame_ready = 1'b0;
    push_frame_exp();
    do_start();
    repeat (5) begin
      @(negedge clk);
      check_val("wait_busy", {31'd0, busy}, 32'd1);
      check_val("wait_novalid", {31'd0, m_valid}, 32'd0);
      check_val("wait_state", {30'd0, dbg_state}, {30'd0, S_WAIT});
      check_val("wait_addr", {12'd0, rd_addr}, BASE);
    end
    @(posedge clk); #1 frame_ready = 1'b1;
    wait_done(4, 100);

    // abort mid-frame with reset, then a clean frame
    push_frame_exp();
    do_start();
    wait_pix(pix_cnt + 3, 50);
    #1 mon_en = 1'b0; resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("abort");
    exp_q.delete();
    stall_prev = 1'b0;
    resetn = 1'b1;
    mon_en = 1'b1;
    push_frame_exp();
    do_start();
    wait_done(5, 100);

    // random backpressure
    rdy_mode = 2;
    push_frame_exp();
    do_start();
    wait_done(6, 300);
    rdy_mode = 0;

    repeat (3) @(posedge clk);
    check_val("q_empty_end", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
